// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller in front of a single-port synchronous RAM.
// The producer pushes on a valid/ready interface and the consumer pops on another.
// The block owns the RAM read/write pointers and arbitrates the single RAM port,
// which allows one access per cycle.
// A 2-entry output buffer hides the one-cycle read latency, so a draining consumer
// can pop one word every cycle.
// Build option: define RAM_FIFO_CTRL_STATS_EN to add the max_level high-water-mark port.
module ram_fifo_ctrl #(
  parameter int addr_width = 6,
  parameter int bus_width  = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [bus_width-1:0]    wr_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [bus_width-1:0]    rd_data,
  output logic [addr_width+1:0]   level,
  output logic                    ram_en,
  output logic                    ram_cs,
  output logic [addr_width-1:0]   ram_addr,
  output logic [bus_width-1:0]    ram_din,
  input  logic [bus_width-1:0]    ram_dout
`ifdef RAM_FIFO_CTRL_STATS_EN
  ,
  output logic [addr_width+1:0]   max_level
`endif
);

  localparam int DEPTH = 2 ** addr_width;
  localparam int CW    = addr_width + 1;  // ram_cnt width, holds 0..DEPTH
  localparam int LW    = addr_width + 2;  // level width, holds 0..DEPTH+2

  logic [addr_width-1:0] wptr_q, wptr_d;
  logic [addr_width-1:0] rptr_q, rptr_d;
  logic [CW-1:0]         ram_cnt_q, ram_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            ob_cnt_q, ob_cnt_d;
  logic [bus_width-1:0]  slot0_q, slot0_d;
  logic [bus_width-1:0]  slot1_q, slot1_d;
  logic [LW-1:0]         level_q, level_d;

  logic       pop;
  logic [2:0] buf_occ;
  logic       fetch_want;
  logic       fetch_wins;
  logic       wr_acc;
  logic       do_fetch;

  // Port arbitration: decide between a write, a fetch, or an idle cycle.
  always_comb begin
    pop        = (ob_cnt_q != 2'd0) && rd_ready;
    // Buffer occupancy after this cycle, counting the word already in flight.
    // A pop only happens when ob_cnt_q > 0, so this cannot underflow.
    buf_occ    = 3'(ob_cnt_q) + 3'(inflight_q) - 3'(pop);
    fetch_want = (ram_cnt_q != '0) && (buf_occ < 3'd2);
    // With an empty buffer, the fetch must win or the consumer would starve.
    fetch_wins = fetch_want && (ob_cnt_q == 2'd0);
    wr_ready   = !rst && !fetch_wins && (ram_cnt_q != CW'(DEPTH));
    wr_acc     = wr_valid && wr_ready;
    do_fetch   = !rst && fetch_want && !wr_acc;

    ram_en     = wr_acc;
    ram_cs     = wr_acc || do_fetch;
    ram_addr   = wr_acc ? wptr_q : rptr_q;
    ram_din    = wr_data;
  end

  // Next-state logic for the pointers, the counters and the output buffer.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can infer a latch.
    wptr_d     = wptr_q + addr_width'(wr_acc);
    rptr_d     = rptr_q + addr_width'(do_fetch);
    ram_cnt_d  = ram_cnt_q + CW'(wr_acc) - CW'(do_fetch);
    inflight_d = do_fetch;
    slot0_d    = slot0_q;
    slot1_d    = slot1_q;
    ob_cnt_d   = ob_cnt_q;

    // Apply the pop first, so that the captured word lands in the slot freed by the shift.
    if (pop) begin
      slot0_d  = slot1_q;
      ob_cnt_d = ob_cnt_d - 2'd1;
    end
    if (inflight_q) begin
      if (ob_cnt_d == 2'd0) slot0_d = ram_dout;
      else                  slot1_d = ram_dout;
      ob_cnt_d = ob_cnt_d + 2'd1;
    end

    level_d = LW'(ram_cnt_d) + LW'(inflight_d) + LW'(ob_cnt_d);
  end

  // State registers with synchronous reset. A pending fetch is dropped on reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      ob_cnt_q   <= 2'd0;
      level_q    <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      ob_cnt_q   <= ob_cnt_d;
      level_q    <= level_d;
    end
  end

  // Buffer data slots: ob_cnt_q qualifies them, so they need no reset.
  always_ff @(posedge clk) begin
    // NOTE: data-only storage is left unreset. Its contents are ignored until ob_cnt_q marks them valid.
    slot0_q <= slot0_d;
    slot1_q <= slot1_d;
  end

  assign rd_valid = (ob_cnt_q != 2'd0);
  assign rd_data  = slot0_q;
  assign level    = level_q;

`ifdef RAM_FIFO_CTRL_STATS_EN
  logic [LW-1:0] max_level_q;

  // High-water mark: follows level upward and is cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)                      max_level_q <= '0;
    else if (level_q > max_level_q) max_level_q <= level_q;
  end

  assign max_level = max_level_q;
`else
  // No high-water-mark tracking in this build.
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with addr_width=2 (DEPTH=4) and bus_width=14, plus a behavioural RAM.
// Inputs are driven at the falling edge and outputs sampled 1ns later.
// Each handshake sampled this way completes on the next rising edge.
module tb_ram_fifo_ctrl;
  localparam int AW = 2;
  localparam int BW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [BW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [BW-1:0] rd_data;
  logic [AW+1:0] level;
  logic          ram_en;
  logic          ram_cs;
  logic [AW-1:0] ram_addr;
  logic [BW-1:0] ram_din;
  logic [BW-1:0] ram_dout;
`ifdef RAM_FIFO_CTRL_STATS_EN
  logic [AW+1:0] max_level;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.addr_width(AW), .bus_width(BW)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .level    (level),
    .ram_en   (ram_en),
    .ram_cs   (ram_cs),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
`ifdef RAM_FIFO_CTRL_STATS_EN
    ,
    .max_level(max_level)
`endif
  );

  // Single-port RAM model. Read data is registered and appears the cycle after the fetch address.
  logic [BW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_en) mem[ram_addr] <= ram_din;
      else        ram_dout      <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Push one word, holding it until it is accepted. Called and returns at a falling edge.
  task automatic push(input logic [BW-1:0] d);
    int n;
    wr_valid = 1'b1;
    wr_data  = d;
    n = 0;
    #1;
    while (!wr_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n == 20) check("push_timeout", 32'd0, 32'd1);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Pop n words with rd_ready held high. Each word must equal base+k.
  // Returns the cycle span between the first and the last pop.
  task automatic drain(input int n, input int base, output int span);
    int got, first, last;
    got = 0; first = -1; last = 0;
    rd_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < n; cyc++) begin
      #1;
      if (rd_valid) begin
        check("drain_data", 32'(rd_data), 32'(base + got));
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      @(negedge clk);
    end
    check("drain_count", 32'(got), 32'(n));
    rd_ready = 1'b0;
    span = last - first;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int span, sent, rcvd, n;

    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    #1 check("rst_wr_ready", 32'(wr_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_level",    32'(level),    32'd0);
    check("reset_ram_cs",   32'(ram_cs),   32'd0);
    check("reset_wr_ready", 32'(wr_ready), 32'd1);

    // Single word: accepted in cycle 0, visible in cycle 3, gone in cycle 4.
    @(negedge clk);
    wr_valid = 1'b1; wr_data = 14'h0A5; rd_ready = 1'b1;
    #1 check("single_accept", 32'(wr_ready & ram_en), 32'd1);
    @(negedge clk); wr_valid = 1'b0;
    #1;
    check("single_c1_fetch", 32'({ram_cs, ram_en}), 32'b10);
    check("single_c1_level", 32'(level), 32'd1);
    check("single_c1_valid", 32'(rd_valid), 32'd0);
    @(negedge clk);
    #1 check("single_c2_valid", 32'(rd_valid), 32'd0);
    @(negedge clk);
    #1;
    check("single_c3_valid", 32'(rd_valid), 32'd1);
    check("single_c3_data",  32'(rd_data),  32'h0A5);
    @(negedge clk);
    #1;
    check("single_c4_valid", 32'(rd_valid), 32'd0);
    check("single_c4_level", 32'(level),    32'd0);
    rd_ready = 1'b0;

    // Fill: six words fit (4 in the RAM, 2 in the buffer), and the seventh is held off.
    @(negedge clk);
    for (int i = 1; i <= 6; i++) push(BW'(i));
    wr_valid = 1'b1; wr_data = 14'h007;
    for (int i = 0; i < 3; i++) begin
      #1 check("full_wr_ready", 32'(wr_ready), 32'd0);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    #1;
    check("full_level", 32'(level),   32'd6);
    check("full_head",  32'(rd_data), 32'h001);
    @(negedge clk);

    // Drain: 1..6 come out in order at one word per cycle.
    drain(6, 1, span);
    check("drain_span", 32'(span), 32'd5);
    #1;
    check("drain_level", 32'(level),    32'd0);
    check("drain_valid", 32'(rd_valid), 32'd0);
    @(negedge clk);

    // Wrap: push and pop in a stream. Order is preserved across several pointer wraps.
    sent = 0; rcvd = 0; n = 0;
    rd_ready = 1'b1;
    while (rcvd < 12 && n < 200) begin
      wr_valid = (sent < 12);
      wr_data  = BW'(14'h100 + sent);
      #1;
      if (wr_valid && wr_ready) sent++;
      if (rd_valid) begin
        check("wrap_data", 32'(rd_data), 32'(14'h100 + rcvd));
        rcvd++;
      end
      @(negedge clk);
      n++;
    end
    wr_valid = 1'b0;
    check("wrap_count", 32'(rcvd), 32'd12);
    for (int i = 0; i < 3; i++) begin
      #1 check("wrap_no_dup", 32'(rd_valid), 32'd0);
      @(negedge clk);
    end
    check("wrap_level", 32'(level), 32'd0);
    rd_ready = 1'b0;

    // Reset mid-stream: level 3 with a fetch issued in the previous cycle.
    push(14'h201); push(14'h202); push(14'h203);
    #1 check("mid_fetch_issue", 32'({ram_cs, ram_en}), 32'b10);
    @(negedge clk);
    #1 check("mid_level3", 32'(level), 32'd3);
    rst = 1'b1;
    #1 check("mid_rst_wr_ready", 32'(wr_ready), 32'd0);
    @(negedge clk);
    #1;
    check("mid_after_valid",    32'(rd_valid), 32'd0);
    check("mid_after_level",    32'(level),    32'd0);
    check("mid_after_wr_ready", 32'(wr_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("mid_idle_cs",    32'(ram_cs),   32'd0);
    check("mid_idle_valid", 32'(rd_valid), 32'd0);
    @(negedge clk);
    push(14'h3FF);
    n = 0;
    #1;
    while (!rd_valid && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("mid_readback_valid", 32'(rd_valid), 32'd1);
    check("mid_readback_data",  32'(rd_data),  32'h3FF);
    @(negedge clk);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    #1;
    check("mid_alone_valid", 32'(rd_valid), 32'd0);
    check("mid_alone_level", 32'(level),    32'd0);
    @(negedge clk);

`ifdef RAM_FIFO_CTRL_STATS_EN
    // Stats: fill to 5, drain, check the mark holds, then clear it with reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 check("stats_reset0", 32'(max_level), 32'd0);
    @(negedge clk);
    for (int i = 1; i <= 5; i++) push(BW'(14'h50 + i));
    @(negedge clk);
    #1 check("stats_level5", 32'(level), 32'd5);
    @(negedge clk);
    drain(5, 14'h51, span);
    @(negedge clk);
    #1;
    check("stats_max_hold",  32'(max_level), 32'd5);
    check("stats_level0",    32'(level),     32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 check("stats_max_clear", 32'(max_level), 32'd0);
    @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
